// File: rtl/reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq
// Description : Multi-domain reset sequencer. Holds every downstream domain
//               in reset for HOLD cycles, then releases domains one at a time
//               (bit 0 first) with GAP cycles between releases. Re-sequences
//               on master reset, software request or watchdog timeout and
//               reports the last cause.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_seq #(
    parameter int N     = 3,
    parameter int HOLD  = 8,
    parameter int GAP   = 4,
    parameter int WDT_W = 16
) (
    input  logic         clock,
    input  logic         reset_ni,
    input  logic         sw_req_i,
    input  logic         wdt_en_i,
    input  logic         wdt_kick_i,
    output logic [N-1:0] domain_reset_o,
    output logic         ready_o,
    output logic [1:0]   cause_o
);

    // Counter wide enough for whichever of HOLD/GAP is longer.
    localparam int C_CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

    localparam logic [C_CNT_W-1:0] C_HOLD_LAST = C_CNT_W'(HOLD - 1);
    localparam logic [C_CNT_W-1:0] C_GAP_LAST  = C_CNT_W'(GAP - 1);

    localparam logic [N-1:0] C_ALL_ONES  = {N{1'b1}};
    // Domain vector after the first release; zero when there is only one domain.
    localparam logic [N-1:0] C_FIRST_REL = C_ALL_ONES << 1;

    localparam logic [1:0] C_CAUSE_MASTER = 2'b00;
    localparam logic [1:0] C_CAUSE_SW     = 2'b01;
    localparam logic [1:0] C_CAUSE_WDT    = 2'b10;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    // Declaration initialisers match the reset values so that the sequence
    // runs straight out of configuration without a reset_ni pulse.
    state_t              r_state        = S_HOLD;
    logic [C_CNT_W-1:0]  r_cnt          = '0;
    logic [N-1:0]        r_domain_reset = C_ALL_ONES;
    logic                r_ready        = 1'b0;
    logic [1:0]          r_cause        = C_CAUSE_MASTER;
    logic [WDT_W-1:0]    r_wdt          = '0;

    logic [N-1:0]        w_next_rel;
    logic                w_wdt_timeout;

    // Domains are released in ascending order, so the lowest asserted bit is
    // always the next one to drop.
    assign w_next_rel    = r_domain_reset & (r_domain_reset - N'(1));

    assign w_wdt_timeout = (r_state == S_RUN) && wdt_en_i && !wdt_kick_i && (&r_wdt);

    // Sequencer state machine with registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_ni) begin
            r_state        <= S_HOLD;
            r_cnt          <= '0;
            r_domain_reset <= C_ALL_ONES;
            r_ready        <= 1'b0;
            r_cause        <= C_CAUSE_MASTER;
        end else begin
            case (r_state)
                S_HOLD: begin
                    r_domain_reset <= C_ALL_ONES;
                    r_ready        <= 1'b0;
                    if (r_cnt == C_HOLD_LAST) begin
                        r_cnt          <= '0;
                        r_domain_reset <= C_FIRST_REL;
                        if (C_FIRST_REL == '0) begin
                            r_state <= S_RUN;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= S_RELEASE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_RELEASE: begin
                    r_ready <= 1'b0;
                    if (r_cnt == C_GAP_LAST) begin
                        r_cnt          <= '0;
                        r_domain_reset <= w_next_rel;
                        if (w_next_rel == '0) begin
                            r_state <= S_RUN;
                            r_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    r_cnt          <= '0;
                    r_domain_reset <= '0;
                    r_ready        <= 1'b1;
                    // Software request takes priority over a simultaneous timeout.
                    if (sw_req_i || w_wdt_timeout) begin
                        r_state        <= S_HOLD;
                        r_domain_reset <= C_ALL_ONES;
                        r_ready        <= 1'b0;
                        r_cause        <= sw_req_i ? C_CAUSE_SW : C_CAUSE_WDT;
                    end
                end

                default: begin
                    r_state        <= S_HOLD;
                    r_cnt          <= '0;
                    r_domain_reset <= C_ALL_ONES;
                    r_ready        <= 1'b0;
                end
            endcase
        end
    end

    // Watchdog counter: only advances while running, enabled and unkicked;
    // wraps to zero naturally on the timeout edge.
    always_ff @(posedge clock) begin
        if (!reset_ni) begin
            r_wdt <= '0;
        end else if ((r_state != S_RUN) || !wdt_en_i || wdt_kick_i) begin
            r_wdt <= '0;
        end else begin
            r_wdt <= r_wdt + 1'b1;
        end
    end

    assign domain_reset_o = r_domain_reset;
    assign ready_o        = r_ready;
    assign cause_o        = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_seq
// Description : Directed self-checking bench for reset_seq (N=3, HOLD=8,
//               GAP=4, WDT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_seq;

    logic       clock      = 1'b0;
    logic       reset_ni   = 1'b1;
    logic       sw_req_i   = 1'b0;
    logic       wdt_en_i   = 1'b0;
    logic       wdt_kick_i = 1'b0;
    logic [2:0] domain_reset_o;
    logic       ready_o;
    logic [1:0] cause_o;

    int n_vec = 0;
    int n_err = 0;

    reset_seq #(
        .N     (3),
        .HOLD  (8),
        .GAP   (4),
        .WDT_W (4)
    ) u_dut (
        .clock          (clock),
        .reset_ni       (reset_ni),
        .sw_req_i       (sw_req_i),
        .wdt_en_i       (wdt_en_i),
        .wdt_kick_i     (wdt_kick_i),
        .domain_reset_o (domain_reset_o),
        .ready_o        (ready_o),
        .cause_o        (cause_o)
    );

    always #5 clock = ~clock;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge.
    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Full release sequence starting with HOLD counter at zero; values are
    // {ready_o, domain_reset_o}.
    task automatic run_seq(input string pfx);
        ticks(7); chk({pfx, ".hold_end"}, {ready_o, domain_reset_o}, 4'b0111);
        ticks(1); chk({pfx, ".bit0_clr"}, {ready_o, domain_reset_o}, 4'b0110);
        ticks(3); chk({pfx, ".gap1_end"}, {ready_o, domain_reset_o}, 4'b0110);
        ticks(1); chk({pfx, ".bit1_clr"}, {ready_o, domain_reset_o}, 4'b0100);
        ticks(3); chk({pfx, ".gap2_end"}, {ready_o, domain_reset_o}, 4'b0100);
        ticks(1); chk({pfx, ".run"},      {ready_o, domain_reset_o}, 4'b1000);
    endtask

    initial begin
        int drops;
        #1;
        // Configuration values before any edge.
        chk("init.outs",  {ready_o, domain_reset_o}, 4'b0111);
        chk("init.cause", cause_o, 2'b00);

        // Startup without any reset_ni pulse.
        run_seq("startup");
        chk("startup.cause", cause_o, 2'b00);

        // One-cycle software request in RUN.
        sw_req_i = 1'b1; ticks(1); sw_req_i = 1'b0;
        chk("sw.outs",  {ready_o, domain_reset_o}, 4'b0111);
        chk("sw.cause", cause_o, 2'b01);
        run_seq("sw");
        chk("sw.cause_run", cause_o, 2'b01);

        // Master reset for 5 cycles in the middle of RELEASE.
        sw_req_i = 1'b1; ticks(1); sw_req_i = 1'b0;
        ticks(9);
        chk("mrst.pre", {ready_o, domain_reset_o}, 4'b0110);
        reset_ni = 1'b0;
        ticks(1);
        chk("mrst.first",  {ready_o, domain_reset_o}, 4'b0111);
        chk("mrst.cause",  cause_o, 2'b00);
        ticks(4);
        chk("mrst.held",   {ready_o, domain_reset_o}, 4'b0111);
        reset_ni = 1'b1;
        run_seq("mrst");
        chk("mrst.cause_run", cause_o, 2'b00);

        // Unserviced watchdog: timeout 16 edges after entering RUN.
        wdt_en_i = 1'b1;
        ticks(15);
        chk("wdt.before", {ready_o, domain_reset_o}, 4'b1000);
        ticks(1);
        chk("wdt.fire",   {ready_o, domain_reset_o}, 4'b0111);
        chk("wdt.cause",  cause_o, 2'b10);
        run_seq("wdt");
        chk("wdt.cause_run", cause_o, 2'b10);

        // Kick every 10 cycles for 1000 cycles: no reset allowed.
        drops = 0;
        for (int i = 0; i < 100; i++) begin
            for (int j = 0; j < 9; j++) begin
                ticks(1);
                if (ready_o !== 1'b1) drops++;
            end
            wdt_kick_i = 1'b1; ticks(1); wdt_kick_i = 1'b0;
            if (ready_o !== 1'b1) drops++;
        end
        chk("kick.drops", drops, 0);

        // Kick landing exactly on the timeout edge clears the counter.
        ticks(15);
        wdt_kick_i = 1'b1; ticks(1); wdt_kick_i = 1'b0;
        chk("kick_edge.noreset", {ready_o, domain_reset_o}, 4'b1000);
        ticks(15);
        chk("kick_edge.before",  {ready_o, domain_reset_o}, 4'b1000);
        ticks(1);
        chk("kick_edge.fire",    {ready_o, domain_reset_o}, 4'b0111);
        chk("kick_edge.cause",   cause_o, 2'b10);
        run_seq("kick_edge");

        // Software request on the timeout edge wins; keep it held through
        // the whole sequence.
        ticks(15);
        sw_req_i = 1'b1; ticks(1);
        chk("both.outs",  {ready_o, domain_reset_o}, 4'b0111);
        chk("both.cause", cause_o, 2'b01);
        run_seq("held");
        ticks(1);
        chk("held.reenter", {ready_o, domain_reset_o}, 4'b0111);
        chk("held.cause",   cause_o, 2'b01);
        sw_req_i = 1'b0;
        wdt_en_i = 1'b0;
        run_seq("final");
        chk("final.cause", cause_o, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
